boolean_variable_selector: RTL and testbench
============================================

Name: boolean_variable_selector

Overview:
- Upstream stage of the Boolean propose block in the MCMC solver.
- Each proposal step, picks which Boolean variable to flip and hands its index to the propose block's variable-index input.
- Index is drawn uniformly from [0, N-1] with a Galois LFSR and rejection sampling. A bounded retry count falls back to a round-robin index.
- Valid/ready handshake toward the propose/control path.

Parameters:
- MAX_BIT_WIDTH_OF_VARIABLES_INDEX, 2, index width W; up to 2**W variables.
- LFSR_WIDTH, 16, LFSR width; must be >= W.
- SEED, 16'hACE1, LFSR reset value; nonzero.
- MAX_RETRIES, 8, rejections allowed before fallback; >= 1.

Ports:
- in_clock  input  1  system clock; all state changes on the rising edge.
- in_reset_n  input  1  asynchronous active-low reset.
- in_enable  input  1  global stall when low: state, LFSR and counters freeze; outputs hold.
- in_start  input  1  request one index; sampled only in IDLE, or in DONE together with in_ready.
- in_number_of_boolean_variables  input  W+1  N, active variable count. Legal 1..2**W; values above 2**W are clamped to 2**W.
- in_ready  input  1  consumer accepts out_variable_to_be_changed_index.
- out_variable_to_be_changed_index  output  W  selected index, registered.
- out_valid  output  1  index valid; held until accepted.
- out_busy  output  1  high in GENERATE.
- out_fallback  output  1  high with out_valid when the index came from the fallback counter.

Behaviour:
- Reset (async assert, sync release): state=IDLE, LFSR=SEED, retry count=0, fallback counter=0. All outputs are 0.
- LFSR step is Galois right shift: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). It steps only on GENERATE edges with in_enable=1.
- Candidate = low W bits of the current (pre-step) LFSR, zero-extended to W+1 bits. It is compared unsigned against N (N is latched on start).
- IDLE:
  - in_enable & in_start & N!=0 → GENERATE; latch N; retry=0.
  - A start with N==0 is ignored; the block stays in IDLE.
- GENERATE (one evaluation per enabled cycle):
  - candidate < N → DONE; index=candidate; out_fallback=0.
  - Reject with retry < MAX_RETRIES-1 → retry+1; stay in GENERATE.
  - Reject with retry == MAX_RETRIES-1 → DONE; index=fallback counter; out_fallback=1; fallback counter = (counter+1 == N) ? 0 : counter+1.
- DONE: out_valid=1. Index and out_fallback stay stable until in_ready.
  - in_ready & in_enable → IDLE, out_valid=0.
  - Same cycle also in_start with N!=0 → GENERATE directly (back-to-back, no idle bubble).
- Latency: start at edge k; first-try accept gives out_valid after edge k+1. Each rejection adds 1 cycle. Worst case is MAX_RETRIES evaluation cycles.
- in_enable low in any state: no transition, no LFSR step, outputs hold. This includes out_valid held in DONE while in_ready is ignored.
- Changes to in_number_of_boolean_variables after start have no effect until the next start.
- Reset mid-GENERATE or mid-DONE: immediate return to reset values; the pending request is discarded.

Optional Feature:
- Macro: BOOLEAN_SELECTOR_SEED_LOAD_EN.
- Defined:
  - Adds ports in_seed_load (input, 1) and in_seed (input, LFSR_WIDTH).
  - In IDLE with in_enable, in_seed_load loads the LFSR with in_seed; a value of 0 loads SEED instead.
  - Seed load has priority over in_start in the same cycle; the start is then ignored.
  - Ignored outside IDLE.
- Undefined: the ports do not exist and the LFSR starts only from SEED.

Test Plan:
- Reset/idle: hold in_reset_n=0 with start pulses → all outputs 0. Release → out_valid=0 until start.
- Uniform sequence, N=4, defaults: four start/ready handshakes → indices 1,0,0,0. Each arrives with out_valid one cycle after start, out_fallback=0. Next two requests give 2 then 3 (LFSR 0x1C4E, 0x0E27).
- Rejection, N=1, defaults: start → 0xACE1 candidate 1 rejected, 0xE270 candidate 0 accepted. Index 0, out_valid two cycles after start, out_busy high for two cycles.
- Fallback, SEED=16'h0003, MAX_RETRIES=2, N=1: candidates 3 then 1 are rejected → index 0 with out_fallback=1.
- Handshake/stall: hold in_ready=0 for 5 cycles → index stable. Drop in_enable for 3 cycles in GENERATE → no progress. Assert in_ready+in_start together → next GENERATE with no idle cycle.
- Illegal and mid-op: start with N=0 → stays IDLE. N=7 with W=2 → behaves as N=4. Assert reset during GENERATE → outputs 0; the next start reproduces the first-request index 1.

Source files
------------

// File: rtl/boolean_variable_selector.sv
// -----------------------------------------------------------------------------
// boolean_variable_selector
//
// Upstream stage of the Boolean propose block. For each request it picks the
// index of the Boolean variable to flip, uniformly over [0, N-1]. It uses a
// Galois LFSR with rejection sampling. After MAX_RETRIES rejections it falls
// back to a round-robin counter, so the worst-case latency stays bounded.
// The result is handed downstream over a valid/ready handshake.
//
// Optional build macro: BOOLEAN_SELECTOR_SEED_LOAD_EN
//   When defined, ports in_seed_load / in_seed let the LFSR be reseeded while
//   the block is idle. A zero seed loads SEED instead, because an all-zero
//   LFSR would lock up.
// -----------------------------------------------------------------------------
module boolean_variable_selector #(
    parameter int                      MAX_BIT_WIDTH_OF_VARIABLES_INDEX = 2,
    parameter int                      LFSR_WIDTH                       = 16,
    parameter logic [LFSR_WIDTH-1:0]   SEED                             = LFSR_WIDTH'(16'hACE1),
    parameter int                      MAX_RETRIES                      = 8
) (
    input  logic                                        in_clock,
    input  logic                                        in_reset_n,
    input  logic                                        in_enable,
    input  logic                                        in_start,
    input  logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX:0]   in_number_of_boolean_variables,
`ifdef BOOLEAN_SELECTOR_SEED_LOAD_EN
    input  logic                                        in_seed_load,
    input  logic [LFSR_WIDTH-1:0]                       in_seed,
`endif
    input  logic                                        in_ready,
    output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] out_variable_to_be_changed_index,
    output logic                                        out_valid,
    output logic                                        out_busy,
    output logic                                        out_fallback
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int W       = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
    localparam int RETRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;

    // N is carried as W+1 bits so that the full count 2**W can be represented.
    localparam logic [W:0]            MAX_N      = {1'b1, {W{1'b0}}};
    localparam logic [LFSR_WIDTH-1:0] TAP_MASK   = LFSR_WIDTH'(16'hB400);
    localparam logic [RETRY_W-1:0]    LAST_RETRY = RETRY_W'(MAX_RETRIES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GENERATE = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                state_q;
    state_t                state_d;
    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [RETRY_W-1:0]    retry_q;
    logic [W:0]            n_q;
    logic [W-1:0]          fallback_count_q;
    logic [W-1:0]          index_q;
    logic                  fallback_q;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                  seed_load_req;
    logic [LFSR_WIDTH-1:0] seed_value;
    logic [W:0]            n_clamped;
    logic                  start_legal;
    logic                  take_start;
    logic [W:0]            candidate;
    logic                  accept;
    logic                  last_try;
    logic                  evaluate;
    logic [LFSR_WIDTH-1:0] lfsr_next;
    logic [W-1:0]          fallback_base;
    logic [W:0]            fallback_inc;
    logic [W-1:0]          fallback_next;
    logic                  handshake;

`ifdef BOOLEAN_SELECTOR_SEED_LOAD_EN
    // Reseeding only matters while idle. A zero seed would freeze the LFSR,
    // so it is replaced by the built-in SEED.
    assign seed_load_req = in_seed_load && (state_q == ST_IDLE);
    assign seed_value    = (in_seed == '0) ? SEED : in_seed;
`else
    assign seed_load_req = 1'b0;
    assign seed_value    = SEED;
`endif

    // Counts above 2**W cannot be addressed by a W-bit index, so clamp them.
    assign n_clamped   = (in_number_of_boolean_variables > MAX_N) ? MAX_N
                                                                  : in_number_of_boolean_variables;
    assign start_legal = in_start && (in_number_of_boolean_variables != '0);

    // The candidate is taken from the current (pre-step) LFSR value.
    assign candidate = {1'b0, lfsr_q[W-1:0]};
    assign accept    = (candidate < n_q);
    assign last_try  = (retry_q == LAST_RETRY);
    assign evaluate  = in_enable && (state_q == ST_GENERATE);
    assign handshake = in_enable && (state_q == ST_DONE) && in_ready;

    // Galois right-shift step.
    assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAP_MASK : '0);

    // The counter may exceed a smaller N latched on a later request. Restart
    // it at zero in that case so the fallback index is always in range.
    assign fallback_base = ({1'b0, fallback_count_q} < n_q) ? fallback_count_q : '0;
    assign fallback_inc  = {1'b0, fallback_base} + (W+1)'(1);
    assign fallback_next = (fallback_inc == n_q) ? '0 : fallback_inc[W-1:0];

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------

    // State register.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments, so
            // every register samples its inputs as they were before the edge.
            state_q <= state_d;
        end
    end

    // Next-state logic and the "a new request is accepted" strobe.
    always_comb begin
        // NOTE: every signal gets a default first. Otherwise a path that skips
        // the assignment would infer a latch.
        state_d    = state_q;
        take_start = 1'b0;

        if (in_enable) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!seed_load_req && start_legal) begin
                        state_d    = ST_GENERATE;
                        take_start = 1'b1;
                    end
                end

                ST_GENERATE: begin
                    if (accept || last_try) begin
                        state_d = ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (in_ready) begin
                        if (start_legal) begin
                            // Back-to-back request: skip the idle bubble.
                            state_d    = ST_GENERATE;
                            take_start = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------

    // LFSR: steps once per enabled evaluation cycle and can be reseeded while idle.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            lfsr_q <= SEED;
        end else if (evaluate) begin
            lfsr_q <= lfsr_next;
        end else if (in_enable && seed_load_req) begin
            lfsr_q <= seed_value;
        end
    end

    // Request context: latch N on start and count rejections while generating.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            n_q     <= '0;
            retry_q <= '0;
        end else if (take_start) begin
            n_q     <= n_clamped;
            retry_q <= '0;
        end else if (evaluate && !accept && !last_try) begin
            retry_q <= retry_q + RETRY_W'(1);
        end
    end

    // Result register: capture the accepted candidate or the fallback index.
    // The result stays stable through DONE, and out_fallback clears on handoff.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            index_q          <= '0;
            fallback_q       <= 1'b0;
            fallback_count_q <= '0;
        end else if (evaluate && accept) begin
            index_q    <= candidate[W-1:0];
            fallback_q <= 1'b0;
        end else if (evaluate && last_try) begin
            index_q          <= fallback_base;
            fallback_q       <= 1'b1;
            fallback_count_q <= fallback_next;
        end else if (handshake) begin
            fallback_q <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_variable_to_be_changed_index = index_q;
    assign out_valid                        = (state_q == ST_DONE);
    assign out_busy                         = (state_q == ST_GENERATE);
    assign out_fallback                     = fallback_q;

endmodule

// File: tb/tb_boolean_variable_selector.sv
// -----------------------------------------------------------------------------
// Testbench for boolean_variable_selector.
// Stimulus processes push the expected index/fallback pairs into queues.
// Monitor processes pop and compare one entry on every completed handshake.
// Two instances are used: one with default parameters and one configured
// (SEED=3, MAX_RETRIES=2) so that it reaches the fallback path.
// -----------------------------------------------------------------------------
module tb_boolean_variable_selector;

    typedef struct packed {
        logic [1:0] idx;
        logic       fb;
    } exp_t;

    logic clk;
    logic rst_n;
    logic enable;

    // Default instance.
    logic       start;
    logic [2:0] n;
    logic       ready;
    logic [1:0] idx;
    logic       valid;
    logic       busy;
    logic       fallback;

    // Fallback-configured instance.
    logic       fb_start;
    logic [2:0] fb_n;
    logic       fb_ready;
    logic [1:0] fb_idx;
    logic       fb_valid;
    logic       fb_busy;
    logic       fb_fallback;

    exp_t exp_q[$];
    exp_t exp_fb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    boolean_variable_selector dut (
        .in_clock                         (clk),
        .in_reset_n                       (rst_n),
        .in_enable                        (enable),
        .in_start                         (start),
        .in_number_of_boolean_variables   (n),
        .in_ready                         (ready),
        .out_variable_to_be_changed_index (idx),
        .out_valid                        (valid),
        .out_busy                         (busy),
        .out_fallback                     (fallback)
    );

    boolean_variable_selector #(
        .SEED        (16'h0003),
        .MAX_RETRIES (2)
    ) dut_fb (
        .in_clock                         (clk),
        .in_reset_n                       (rst_n),
        .in_enable                        (enable),
        .in_start                         (fb_start),
        .in_number_of_boolean_variables   (fb_n),
        .in_ready                         (fb_ready),
        .out_variable_to_be_changed_index (fb_idx),
        .out_valid                        (fb_valid),
        .out_busy                         (fb_busy),
        .out_fallback                     (fb_fallback)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Default-instance scoreboard: compare on every accepted output.
    always @(negedge clk) begin
        if (rst_n && enable && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got idx %0d with empty queue", idx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_index", idx, e.idx);
                check("sb_fallback", fallback, e.fb);
            end
        end
    end

    // Fallback-instance scoreboard.
    always @(negedge clk) begin
        if (rst_n && enable && fb_valid && fb_ready) begin
            if (exp_fb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL fb_sb_unexpected: got idx %0d with empty queue", fb_idx);
            end else begin
                exp_t e;
                e = exp_fb_q.pop_front();
                check("fb_sb_index", fb_idx, e.idx);
                check("fb_sb_fallback", fb_fallback, e.fb);
            end
        end
    end

    // One request on the default instance: start, wait (bounded), then accept.
    // n_after is driven on N right after start, to show that N is latched.
    task automatic request(input logic [2:0] n_start, input logic [2:0] n_after,
                           input logic [1:0] exp_idx, input int exp_lat);
        int cycles;
        exp_q.push_back('{idx: exp_idx, fb: 1'b0});
        n     = n_start;
        start = 1'b1;
        step();
        start = 1'b0;
        n     = n_after;
        check("busy_after_start", busy, 1'b1);
        cycles = 0;
        while (!valid && cycles < 50) begin
            step();
            cycles++;
        end
        check("latency", cycles, exp_lat);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("valid_cleared", valid, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int cycles;

        rst_n    = 1'b0;
        enable   = 1'b1;
        start    = 1'b0;
        n        = 3'd4;
        ready    = 1'b0;
        fb_start = 1'b0;
        fb_n     = 3'd1;
        fb_ready = 1'b0;

        // Reset held with start pulses: every output stays zero.
        #1;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            step();
            check("rst_valid", valid, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_index", idx, 2'd0);
            check("rst_fallback", fallback, 1'b0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_valid", valid, 1'b0);
            check("idle_busy", busy, 1'b0);
        end

        // Uniform sequence, N=4: LFSR ACE1,E270,7138,389C,1C4E,0E27.
        request(3'd4, 3'd4, 2'd1, 1);
        request(3'd4, 3'd4, 2'd0, 1);
        request(3'd4, 3'd4, 2'd0, 1);
        request(3'd4, 3'd4, 2'd0, 1);
        request(3'd4, 3'd4, 2'd2, 1);
        request(3'd4, 3'd4, 2'd3, 1);

        // Rejection, N=1 from reset: candidate 1 rejected, then 0 accepted.
        do_reset();
        request(3'd1, 3'd1, 2'd0, 2);

        // Ready held low for 5 cycles (LFSR 7138 gives candidate 0).
        exp_q.push_back('{idx: 2'd0, fb: 1'b0});
        n     = 3'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", valid, 1'b1);
            check("hold_index", idx, 2'd0);
            step();
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("hold_released", valid, 1'b0);

        // Enable dropped for 3 cycles in GENERATE (LFSR 389C gives candidate 0).
        exp_q.push_back('{idx: 2'd0, fb: 1'b0});
        start = 1'b1;
        step();
        start  = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_busy", busy, 1'b1);
            check("stall_valid", valid, 1'b0);
        end
        enable = 1'b1;
        step();
        check("stall_done_valid", valid, 1'b1);

        // Enable low in DONE: ready is ignored and valid holds.
        enable = 1'b0;
        ready  = 1'b1;
        step();
        step();
        check("stall_done_hold", valid, 1'b1);

        // Ready and start together: straight back to GENERATE (LFSR 1C4E -> 2).
        exp_q.push_back('{idx: 2'd2, fb: 1'b0});
        enable = 1'b1;
        start  = 1'b1;
        step();
        start = 1'b0;
        ready = 1'b0;
        check("b2b_busy", busy, 1'b1);
        check("b2b_valid", valid, 1'b0);
        step();
        check("b2b_result_valid", valid, 1'b1);
        ready = 1'b1;
        step();
        ready = 1'b0;

        // Start with N=0 is ignored.
        n     = 3'd0;
        start = 1'b1;
        step();
        check("n0_busy", busy, 1'b0);
        step();
        start = 1'b0;
        check("n0_valid", valid, 1'b0);
        check("n0_busy2", busy, 1'b0);

        // N=7 is clamped to 4 (LFSR 0E27 -> 3, accepted at once).
        request(3'd7, 3'd7, 2'd3, 1);

        // N latched at start: N=1, then input raised to 4.
        // LFSR B313 (3) and ED89 (1) rejected, C2C4 (0) accepted.
        request(3'd1, 3'd4, 2'd0, 3);

        // Reset during GENERATE (LFSR 6162 -> 2, rejected for N=1).
        n     = 3'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", valid, 1'b0);
        check("mid_rst_index", idx, 2'd0);
        step();
        rst_n = 1'b1;
        step();
        request(3'd4, 3'd4, 2'd1, 1);

        // Fallback instance: SEED 0003 -> 3 rejected, B401 -> 1 rejected, then fallback 0.
        exp_fb_q.push_back('{idx: 2'd0, fb: 1'b1});
        fb_n     = 3'd1;
        fb_start = 1'b1;
        step();
        fb_start = 1'b0;
        cycles = 0;
        while (!fb_valid && cycles < 50) begin
            step();
            cycles++;
        end
        check("fb_latency", cycles, 2);
        check("fb_flag_done", fb_fallback, 1'b1);
        fb_ready = 1'b1;
        step();
        fb_ready = 1'b0;
        check("fb_flag_cleared", fb_fallback, 1'b0);

        // Next request on the fallback instance: LFSR EE00 -> 0, accepted at once.
        exp_fb_q.push_back('{idx: 2'd0, fb: 1'b0});
        fb_start = 1'b1;
        step();
        fb_start = 1'b0;
        cycles = 0;
        while (!fb_valid && cycles < 50) begin
            step();
            cycles++;
        end
        check("fb_latency2", cycles, 1);
        fb_ready = 1'b1;
        step();
        fb_ready = 1'b0;

        step();
        check("sb_drained", exp_q.size(), 0);
        check("fb_sb_drained", exp_fb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
